player_motion_collision: RTL and testbench



---
 rtl/player_motion_collision_pkg.sv | 35 +++
 rtl/player_motion_collision_dir_latch.sv | 39 +++
 rtl/player_motion_collision.sv | 223 ++++++++++++++++++++++
 tb/tb_player_motion_collision.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_motion_collision_pkg.sv
// Shared game types for the light-cycle core: grid size (also used by the
// renderer), movement directions with their reversal helper, and the game
// mode encoding produced by the mode FSM.
package player_motion_collision_pkg;

    localparam int GRID_W = 64;
    localparam int GRID_H = 48;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        START   = 2'd0,
        GAME    = 2'd1,
        P1_WINS = 2'd2,
        P2_WINS = 2'd3
    } game_mode;

    // 180-degree counterpart of a direction; WAIT has none.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      opposite = DOWN;
            DOWN:    opposite = UP;
            LEFT:    opposite = RIGHT;
            RIGHT:   opposite = LEFT;
            default: opposite = WAIT;
        endcase
    endfunction

endpackage

// File: rtl/player_motion_collision_dir_latch.sv
// Pending-direction register for one player.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_clear       drop any pending request (game not running)
//   i_cur_dir     direction the request is judged against
//   i_req/i_vld   requested direction and its one-cycle strobe
//   o_pending     last accepted request, WAIT if none
// A request is accepted unless it is WAIT or a reversal of i_cur_dir;
// a rejected request leaves the pending value untouched.
module player_motion_collision_dir_latch
    import player_motion_collision_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  dir_t i_cur_dir,
    input  dir_t i_req,
    input  logic i_vld,
    output dir_t o_pending
);

    dir_t r_pending;

    // Pending register: last valid request wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= WAIT;
        end else if (i_clear) begin
            r_pending <= WAIT;
        end else if (i_vld && (i_req != WAIT) && (i_req != opposite(i_cur_dir))) begin
            r_pending <= i_req;
        end else begin
            r_pending <= r_pending;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/player_motion_collision.sv
// Moves both player heads across the cell grid and detects deaths.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_mode                          game mode; the block only runs in GAME
//   i_frame_tick                    one pulse per video frame
//   i_pN_dir_req / i_pN_dir_vld     steering request and strobe per player
//   o_occ_rd_en/_x/_y, i_occ_rd_data trail RAM read, data one cycle later
//   o_occ_wr_en/_x/_y/_player       trail RAM cell set (player 0 = P1)
//   o_occ_clr                       clear-all pulse at game start
//   o_pN_x / o_pN_y                 current head cells
//   o_player1/2_collision           death flags, held until GAME is left
module player_motion_collision
    import player_motion_collision_pkg::*;
#(
    parameter int GRID_W      = player_motion_collision_pkg::GRID_W,
    parameter int GRID_H      = player_motion_collision_pkg::GRID_H,
    parameter int STEP_FRAMES = 6,
    parameter int P1_X0       = 8,
    parameter int P1_Y0       = 24,
    parameter int P2_X0       = 55,
    parameter int P2_Y0       = 24,
    localparam int X_W        = $clog2(GRID_W),
    localparam int Y_W        = $clog2(GRID_H)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  game_mode       i_mode,
    input  logic           i_frame_tick,
    input  dir_t           i_p1_dir_req,
    input  dir_t           i_p2_dir_req,
    input  logic           i_p1_dir_vld,
    input  logic           i_p2_dir_vld,
    output logic           o_occ_rd_en,
    output logic [X_W-1:0] o_occ_rd_x,
    output logic [Y_W-1:0] o_occ_rd_y,
    input  logic           i_occ_rd_data,
    output logic           o_occ_wr_en,
    output logic [X_W-1:0] o_occ_wr_x,
    output logic [Y_W-1:0] o_occ_wr_y,
    output logic           o_occ_wr_player,
    output logic           o_occ_clr,
    output logic [X_W-1:0] o_p1_x,
    output logic [Y_W-1:0] o_p1_y,
    output logic [X_W-1:0] o_p2_x,
    output logic [Y_W-1:0] o_p2_y,
    output logic           o_player1_collision,
    output logic           o_player2_collision
);

    localparam int CNT_W = $clog2(STEP_FRAMES + 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0, S_INIT1 = 4'd1, S_INIT2 = 4'd2, S_RUN  = 4'd3,
        S_RD1   = 4'd4, S_RD2   = 4'd5, S_EVAL  = 4'd6, S_WR1  = 4'd7,
        S_WR2   = 4'd8, S_DEAD  = 4'd9
    } state_t;

    // When oob is set the cell keeps the current head: no arithmetic past the edge.
    typedef struct packed {
        logic           oob;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } cell_t;

    function automatic cell_t step_cell(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                        input dir_t d);
        step_cell.x   = x;
        step_cell.y   = y;
        step_cell.oob = 1'b0;
        case (d)
            UP:      if (y == {Y_W{1'b0}}) step_cell.oob = 1'b1; else step_cell.y = y - Y_W'(1);
            DOWN:    if (y == Y_W'(GRID_H - 1)) step_cell.oob = 1'b1; else step_cell.y = y + Y_W'(1);
            LEFT:    if (x == {X_W{1'b0}}) step_cell.oob = 1'b1; else step_cell.x = x - X_W'(1);
            RIGHT:   if (x == X_W'(GRID_W - 1)) step_cell.oob = 1'b1; else step_cell.x = x + X_W'(1);
            default: step_cell.oob = 1'b0;
        endcase
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    dir_t             r_dir1, r_dir2;
    cell_t            r_n1, r_n2;
    logic             r_hit1;
    logic [X_W-1:0]   r_p1_x, r_p2_x, r_rd_x, r_wr_x;
    logic [Y_W-1:0]   r_p1_y, r_p2_y, r_rd_y, r_wr_y;
    logic             r_rd_en, r_wr_en, r_wr_player, r_clr, r_col1, r_col2;

    dir_t  w_pend1, w_pend2, w_d1, w_d2, w_chk1, w_chk2;
    cell_t w_c1, w_c2;
    logic  w_step, w_clear, w_same, w_swap, w_die1, w_die2;

    assign w_clear = (r_state == S_IDLE) || (i_mode != GAME);
    assign w_step  = (i_mode == GAME) && (r_state == S_RUN) && i_frame_tick &&
                     (r_cnt == CNT_W'(STEP_FRAMES - 1));

    // Direction for the coming step and the next cells it leads to.
    always_comb begin
        w_d1 = (w_pend1 != WAIT) ? w_pend1 : r_dir1;
        w_d2 = (w_pend2 != WAIT) ? w_pend2 : r_dir2;
        w_c1 = step_cell(r_p1_x, r_p1_y, w_d1);
        w_c2 = step_cell(r_p2_x, r_p2_y, w_d2);
        // A request arriving on the step cycle is judged against the new direction.
        w_chk1 = w_step ? w_d1 : r_dir1;
        w_chk2 = w_step ? w_d2 : r_dir2;
    end

    // Death decision in EVAL; the second read's data is on i_occ_rd_data this cycle.
    always_comb begin
        w_same = !r_n1.oob && !r_n2.oob && (r_n1.x == r_n2.x) && (r_n1.y == r_n2.y);
        w_swap = (r_n1.x == r_p2_x) && (r_n1.y == r_p2_y) &&
                 (r_n2.x == r_p1_x) && (r_n2.y == r_p1_y);
        w_die1 = r_n1.oob | r_hit1 | w_same | w_swap;
        w_die2 = r_n2.oob | i_occ_rd_data | w_same | w_swap;
    end

    player_motion_collision_dir_latch u_dir1 (
        .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_cur_dir(w_chk1),
        .i_req(i_p1_dir_req), .i_vld(i_p1_dir_vld), .o_pending(w_pend1)
    );

    player_motion_collision_dir_latch u_dir2 (
        .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_cur_dir(w_chk2),
        .i_req(i_p2_dir_req), .i_vld(i_p2_dir_vld), .o_pending(w_pend2)
    );

    // Main FSM: step pacing, RAM sequencing, head update and death flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;      r_cnt <= {CNT_W{1'b0}};
            r_dir1  <= RIGHT;       r_dir2 <= LEFT;
            r_n1    <= '0;          r_n2   <= '0;       r_hit1 <= 1'b0;
            r_p1_x  <= X_W'(P1_X0); r_p1_y <= Y_W'(P1_Y0);
            r_p2_x  <= X_W'(P2_X0); r_p2_y <= Y_W'(P2_Y0);
            r_rd_en <= 1'b0; r_rd_x <= {X_W{1'b0}}; r_rd_y <= {Y_W{1'b0}};
            r_wr_en <= 1'b0; r_wr_x <= {X_W{1'b0}}; r_wr_y <= {Y_W{1'b0}};
            r_wr_player <= 1'b0; r_clr <= 1'b0; r_col1 <= 1'b0; r_col2 <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_clr   <= 1'b0;
            if (i_mode != GAME) begin
                r_state <= S_IDLE;      r_cnt <= {CNT_W{1'b0}};
                r_dir1  <= RIGHT;       r_dir2 <= LEFT;
                r_p1_x  <= X_W'(P1_X0); r_p1_y <= Y_W'(P1_Y0);
                r_p2_x  <= X_W'(P2_X0); r_p2_y <= Y_W'(P2_Y0);
                r_col1  <= 1'b0;        r_col2 <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clr   <= 1'b1;
                        r_state <= S_INIT1;
                    end
                    S_INIT1: begin
                        r_wr_en <= 1'b1; r_wr_x <= X_W'(P1_X0); r_wr_y <= Y_W'(P1_Y0);
                        r_wr_player <= 1'b0;
                        r_state <= S_INIT2;
                    end
                    S_INIT2: begin
                        r_wr_en <= 1'b1; r_wr_x <= X_W'(P2_X0); r_wr_y <= Y_W'(P2_Y0);
                        r_wr_player <= 1'b1;
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_step) begin
                            r_cnt   <= {CNT_W{1'b0}};
                            r_dir1  <= w_d1;  r_dir2 <= w_d2;
                            r_n1    <= w_c1;  r_n2   <= w_c2;
                            r_rd_en <= 1'b1;  r_rd_x <= w_c1.x; r_rd_y <= w_c1.y;
                            r_state <= S_RD1;
                        end else if (i_frame_tick) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RD1: begin
                        r_rd_en <= 1'b1; r_rd_x <= r_n2.x; r_rd_y <= r_n2.y;
                        r_state <= S_RD2;
                    end
                    S_RD2: begin
                        r_hit1  <= i_occ_rd_data;
                        r_state <= S_EVAL;
                    end
                    S_EVAL: begin
                        if (w_die1 || w_die2) begin
                            r_col1  <= w_die1;
                            r_col2  <= w_die2;
                            r_state <= S_DEAD;
                        end else begin
                            r_p1_x  <= r_n1.x; r_p1_y <= r_n1.y;
                            r_p2_x  <= r_n2.x; r_p2_y <= r_n2.y;
                            r_wr_en <= 1'b1; r_wr_x <= r_n1.x; r_wr_y <= r_n1.y;
                            r_wr_player <= 1'b0;
                            r_state <= S_WR1;
                        end
                    end
                    S_WR1: begin
                        r_wr_en <= 1'b1; r_wr_x <= r_n2.x; r_wr_y <= r_n2.y;
                        r_wr_player <= 1'b1;
                        r_state <= S_WR2;
                    end
                    S_WR2:   r_state <= S_RUN;
                    S_DEAD:  r_state <= S_DEAD;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_occ_rd_en         = r_rd_en;
    assign o_occ_rd_x          = r_rd_x;
    assign o_occ_rd_y          = r_rd_y;
    assign o_occ_wr_en         = r_wr_en;
    assign o_occ_wr_x          = r_wr_x;
    assign o_occ_wr_y          = r_wr_y;
    assign o_occ_wr_player     = r_wr_player;
    assign o_occ_clr           = r_clr;
    assign o_p1_x              = r_p1_x;
    assign o_p1_y              = r_p1_y;
    assign o_p2_x              = r_p2_x;
    assign o_p2_y              = r_p2_y;
    assign o_player1_collision = r_col1;
    assign o_player2_collision = r_col2;

endmodule

// File: tb/tb_player_motion_collision.sv
// Bench: a reference game model predicts trail writes (queued, popped when
// the DUT writes), head cells and death flags. A behavioural trail RAM
// serves the DUT's reads. A second instance starts heads two cells apart
// to exercise the same-cell head-on case.
module tb_player_motion_collision;
    import player_motion_collision_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst_n = 1'b0;
    game_mode mode = START;
    logic     tick = 1'b0;
    dir_t     p1_req = WAIT, p2_req = WAIT;
    logic     p1_vld = 1'b0, p2_vld = 1'b0;
    logic     rd_en, wr_en, wr_pl, clr, col1, col2;
    logic     rd_data = 1'b0;
    logic [5:0] rd_x, rd_y, wr_x, wr_y, p1x, p1y, p2x, p2y;

    // second instance: no steering, empty RAM
    dir_t b_req = WAIT;
    logic b_vld = 1'b0, b_rd_data = 1'b0;
    logic b_rd_en, b_wr_en, b_wr_pl, b_clr, b_col1, b_col2;
    logic [5:0] b_rd_x, b_rd_y, b_wr_x, b_wr_y, b_p1x, b_p1y, b_p2x, b_p2y;

    player_motion_collision u_dut (
        .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_frame_tick(tick),
        .i_p1_dir_req(p1_req), .i_p2_dir_req(p2_req), .i_p1_dir_vld(p1_vld), .i_p2_dir_vld(p2_vld),
        .o_occ_rd_en(rd_en), .o_occ_rd_x(rd_x), .o_occ_rd_y(rd_y), .i_occ_rd_data(rd_data),
        .o_occ_wr_en(wr_en), .o_occ_wr_x(wr_x), .o_occ_wr_y(wr_y), .o_occ_wr_player(wr_pl),
        .o_occ_clr(clr), .o_p1_x(p1x), .o_p1_y(p1y), .o_p2_x(p2x), .o_p2_y(p2y),
        .o_player1_collision(col1), .o_player2_collision(col2)
    );

    player_motion_collision #(.P1_X0(30), .P1_Y0(24), .P2_X0(32), .P2_Y0(24)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_frame_tick(tick),
        .i_p1_dir_req(b_req), .i_p2_dir_req(b_req), .i_p1_dir_vld(b_vld), .i_p2_dir_vld(b_vld),
        .o_occ_rd_en(b_rd_en), .o_occ_rd_x(b_rd_x), .o_occ_rd_y(b_rd_y), .i_occ_rd_data(b_rd_data),
        .o_occ_wr_en(b_wr_en), .o_occ_wr_x(b_wr_x), .o_occ_wr_y(b_wr_y), .o_occ_wr_player(b_wr_pl),
        .o_occ_clr(b_clr), .o_p1_x(b_p1x), .o_p1_y(b_p1y), .o_p2_x(b_p2x), .o_p2_y(b_p2y),
        .o_player1_collision(b_col1), .o_player2_collision(b_col2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // behavioural trail RAM
    logic mem [0:3071];
    logic inj_en = 1'b0;
    int   inj_idx = 0;
    always @(posedge clk) begin
        if (clr) for (int i = 0; i < 3072; i++) mem[i] <= 1'b0;
        if (wr_en) mem[int'(wr_y) * 64 + int'(wr_x)] <= 1'b1;
        if (rd_en) rd_data <= mem[int'(rd_y) * 64 + int'(rd_x)] |
                              (inj_en && (int'(rd_y) * 64 + int'(rd_x) == inj_idx));
    end

    // scoreboard of expected writes: player*4096 + y*64 + x
    int exp_wr[$];
    int clr_cnt = 0;
    int b_wr_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en || wr_en || clr)
                check("strobe_excl", 32'(rd_en) + 32'(wr_en) + 32'(clr), 32'd1);
            if (clr) clr_cnt <= clr_cnt + 1;
            if (b_wr_en) b_wr_cnt <= b_wr_cnt + 1;
            if (wr_en) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 32'({wr_pl, wr_y, wr_x}), 32'hFFFF_FFFF);
                else check("wr_cell", 32'({wr_pl, wr_y, wr_x}), exp_wr.pop_front());
            end
        end
    end

    // reference model
    int   m_x1, m_y1, m_x2, m_y2;
    dir_t m_d1, m_d2, m_pd1, m_pd2;
    bit   m_grid [0:3071];
    bit   m_col1, m_col2;

    function automatic dir_t rev(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            default: return WAIT;
        endcase
    endfunction

    task automatic m_next(input int x, input int y, input dir_t d,
                          output int nx, output int ny, output bit oob);
        nx = x; ny = y;
        case (d)
            UP:      ny = y - 1;
            DOWN:    ny = y + 1;
            LEFT:    nx = x - 1;
            RIGHT:   nx = x + 1;
            default: nx = x;
        endcase
        oob = (nx < 0) || (nx > 63) || (ny < 0) || (ny > 47);
        if (oob) begin nx = x; ny = y; end
    endtask

    task automatic model_start();
        m_x1 = 8; m_y1 = 24; m_x2 = 55; m_y2 = 24;
        m_d1 = RIGHT; m_d2 = LEFT; m_pd1 = WAIT; m_pd2 = WAIT;
        m_col1 = 0; m_col2 = 0;
        for (int i = 0; i < 3072; i++) m_grid[i] = 0;
        m_grid[24 * 64 + 8] = 1; m_grid[24 * 64 + 55] = 1;
        exp_wr.push_back(24 * 64 + 8);
        exp_wr.push_back(4096 + 24 * 64 + 55);
    endtask

    task automatic model_step();
        int nx1, ny1, nx2, ny2;
        bit o1, o2, same, swp, die1, die2;
        if (m_pd1 != WAIT) m_d1 = m_pd1;
        if (m_pd2 != WAIT) m_d2 = m_pd2;
        m_next(m_x1, m_y1, m_d1, nx1, ny1, o1);
        m_next(m_x2, m_y2, m_d2, nx2, ny2, o2);
        same = !o1 && !o2 && nx1 == nx2 && ny1 == ny2;
        swp  = nx1 == m_x2 && ny1 == m_y2 && nx2 == m_x1 && ny2 == m_y1;
        die1 = o1 || m_grid[ny1 * 64 + nx1] || same || swp;
        die2 = o2 || m_grid[ny2 * 64 + nx2] || same || swp;
        if (die1 || die2) begin
            m_col1 = die1; m_col2 = die2;
        end else begin
            m_x1 = nx1; m_y1 = ny1; m_x2 = nx2; m_y2 = ny2;
            m_grid[ny1 * 64 + nx1] = 1; m_grid[ny2 * 64 + nx2] = 1;
            exp_wr.push_back(ny1 * 64 + nx1);
            exp_wr.push_back(4096 + ny2 * 64 + nx2);
        end
    endtask

    task automatic req(input int p, input dir_t d);
        @(negedge clk);
        if (p == 1) begin
            p1_req = d; p1_vld = 1'b1;
            if (d != WAIT && d != rev(m_d1)) m_pd1 = d;
        end else begin
            p2_req = d; p2_vld = 1'b1;
            if (d != WAIT && d != rev(m_d2)) m_pd2 = d;
        end
        @(negedge clk);
        p1_vld = 1'b0; p2_vld = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_p1x"}, p1x, m_x1);
        check({tag, "_p1y"}, p1y, m_y1);
        check({tag, "_p2x"}, p2x, m_x2);
        check({tag, "_p2y"}, p2y, m_y2);
        check({tag, "_col1"}, col1, m_col1);
        check({tag, "_col2"}, col2, m_col2);
    endtask

    // six spaced frame ticks; the sixth triggers a step
    task automatic do_step();
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t == 5) begin
                check("hold_before_6th_tick", p1x, m_x1);
                model_step();
            end
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat (6) @(negedge clk);
        end
        check_model("step");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_p1x", p1x, 8);   check("rst_p1y", p1y, 24);
        check("rst_p2x", p2x, 55);  check("rst_p2y", p2y, 24);
        check("rst_col1", col1, 0); check("rst_col2", col2, 0);
        check("rst_wr_en", wr_en, 0); check("rst_clr", clr, 0);
        rst_n = 1'b1;
        // ticks outside GAME must not advance anything
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end

        // game 1: start, plain step, steering, wall death
        model_start();
        @(negedge clk) mode = GAME;
        repeat (8) @(negedge clk);
        check("clr_pulses", clr_cnt, 1);
        do_step();
        check("first_step_p1x", p1x, 9);
        check("first_step_p2x", p2x, 54);
        check("headon_col1", b_col1, 1);
        check("headon_col2", b_col2, 1);
        check("headon_no_write", b_wr_cnt, 2);
        check("headon_frozen", b_p1x, 30);
        req(1, LEFT);
        do_step();
        check("reverse_dropped", p1x, 10);
        req(1, LEFT);
        req(1, UP);
        do_step();
        check("up_applied", p1y, 23);
        req(2, DOWN);
        for (int i = 0; i < 13; i++) do_step();
        req(1, RIGHT);
        for (int i = 0; i < 53; i++) begin
            if (i == 7) req(2, LEFT);
            do_step();
        end
        check("at_edge_x", p1x, 63);
        check("at_edge_y", p1y, 10);
        do_step();
        check("wall_col1", col1, 1);
        check("wall_col2", col2, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
        check("dead_held_col1", col1, 1);
        check("dead_frozen_x", p1x, 63);
        @(negedge clk) mode = START;
        @(negedge clk);
        check("leave_game_col1", col1, 0);
        check("leave_game_p1x", p1x, 8);

        // game 2: obstacle only in P2's next cell
        model_start();
        inj_en = 1'b1; inj_idx = 24 * 64 + 54; m_grid[24 * 64 + 54] = 1;
        @(negedge clk) mode = GAME;
        repeat (8) @(negedge clk);
        check("clr_pulses_2", clr_cnt, 2);
        do_step();
        check("hit2_col2", col2, 1);
        check("hit2_col1", col1, 0);
        @(negedge clk) mode = START;
        @(negedge clk);
        check("clear_next_col2", col2, 0);
        inj_en = 1'b0;

        // game 3: reset in the middle of RUN
        model_start();
        @(negedge clk) mode = GAME;
        repeat (8) @(negedge clk);
        do_step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0; mode = START;
        #1;
        check("midrst_p1x", p1x, 8);  check("midrst_p2x", p2x, 55);
        check("midrst_p1y", p1y, 24); check("midrst_col", {col1, col2}, 0);
        check("midrst_occ", {rd_en, wr_en, clr}, 0);
        check("midrst_wr_x", wr_x, 0);
        check("sb_empty", exp_wr.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
